// File: rtl/kmkz_csr_pkg.sv
// Shared constants for the Kamikaze-uRV machine-mode CSR unit:
// CSR addresses, funct3 op codes, misa value and mcountinhibit bit positions.
package kmkz_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;

  localparam logic [2:0] CSR_OP_RW  = 3'b001;
  localparam logic [2:0] CSR_OP_RS  = 3'b010;
  localparam logic [2:0] CSR_OP_RC  = 3'b011;
  localparam logic [2:0] CSR_OP_RWI = 3'b101;
  localparam logic [2:0] CSR_OP_RSI = 3'b110;
  localparam logic [2:0] CSR_OP_RCI = 3'b111;

  localparam logic [31:0] MISA_VALUE = 32'h4000_1104;

  localparam int INH_CY  = 0;
  localparam int INH_IR  = 2;
  localparam int INH_HPM = 3;

  // Address offset (low 5 bits) of counter bank slot idx: mcycle, minstret, hpm3..
  function automatic logic [4:0] cnt_offset(input int idx);
    if (idx == 0) return 5'd0;
    else if (idx == 1) return 5'd2;
    else return 5'(idx + 1);
  endfunction

endpackage

// File: rtl/kmkz_csr_counter.sv
// One writable hardware counter; each 32-bit half is loadable on its own and a
// load takes priority over the increment in the same cycle.
module kmkz_csr_counter #(
  parameter int W = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          wr_lo_i,
  input  logic          wr_hi_i,
  input  logic [31:0]   wdata_i,
  output logic [W-1:0]  value_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      value_o <= '0;
    end else if (wr_lo_i) begin
      value_o[31:0] <= wdata_i;
    end else if (wr_hi_i) begin
      value_o[W-1:32] <= wdata_i[W-33:0];
    end else if (inc_i) begin
      value_o <= value_o + W'(1);
    end
  end

endmodule

// File: rtl/kmkz_csr_unit.sv
// Machine-mode CSR unit: CSRRW/RS/RC(+I) datapath, counter bank, mcountinhibit,
// mhpmevent enables, mscratch and WARL mtvec; trap CSRs are read-only views.
module kmkz_csr_unit
  import kmkz_csr_pkg::*;
#(
  parameter int NUM_HPM      = 4,
  parameter int CNT_W        = 64,
  parameter bit MTVEC_VEC_EN = 1'b1,
  localparam int HPM_W       = (NUM_HPM > 0) ? NUM_HPM : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              x_stall_i,
  input  logic              x_kill_i,
  input  logic              d_is_csr_i,
  input  logic [2:0]        d_fun_i,
  input  logic [4:0]        d_csr_imm_i,
  input  logic [11:0]       d_csr_sel_i,
  input  logic [31:0]       d_rs1_i,
  input  logic              retire_i,
  input  logic [HPM_W-1:0]  hpm_event_i,
  input  logic [31:0]       csr_mstatus_i,
  input  logic [31:0]       csr_mip_i,
  input  logic [31:0]       csr_mie_i,
  input  logic [31:0]       csr_mepc_i,
  input  logic [31:0]       csr_mcause_i,
  input  logic [31:0]       startup_address,
  output logic [31:0]       x_rd_o,
  output logic [31:0]       x_csr_write_value_o,
  output logic              x_illegal_o,
  output logic [31:0]       vector_base_o,
  output logic [1:0]        vector_mode_o
);

  localparam int NCNT = 2 + NUM_HPM;
  localparam logic [31:0] INH_MASK =
    32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << INH_HPM);

  logic [31:0]      mcountinhibit;
  logic [31:0]      mscratch;
  logic [31:0]      mtvec;
  logic [HPM_W-1:0] hpm_en;

  logic [CNT_W-1:0] cnt_val [NCNT];
  logic [63:0]      cnt_ext [NCNT];
  logic [NCNT-1:0]  cnt_inc;
  logic [NCNT-1:0]  cnt_wr_lo;
  logic [NCNT-1:0]  cnt_wr_hi;

  logic [31:0] src;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        mapped;
  logic        wr_intent;
  logic        commit;

  always_comb begin
    src       = d_fun_i[2] ? {27'd0, d_csr_imm_i} : d_rs1_i;
    // Set/clear forms with a zero rs1 field are pure reads.
    wr_intent = (d_fun_i[1:0] == 2'b01) || (d_fun_i[1] && (d_csr_imm_i != 5'd0));

    old_val = '0;
    mapped  = 1'b1;
    case (d_csr_sel_i)
      CSR_MSTATUS:       old_val = csr_mstatus_i;
      CSR_MISA:          old_val = MISA_VALUE;
      CSR_MIE:           old_val = csr_mie_i;
      CSR_MTVEC:         old_val = mtvec;
      CSR_MCOUNTINHIBIT: old_val = mcountinhibit;
      CSR_MSCRATCH:      old_val = mscratch;
      CSR_MEPC:          old_val = csr_mepc_i;
      CSR_MCAUSE:        old_val = csr_mcause_i;
      CSR_MIP:           old_val = csr_mip_i;
      default:           mapped  = 1'b0;
    endcase

    for (int n = 0; n < NUM_HPM; n++) begin
      if (d_csr_sel_i == CSR_MHPMEVENT3 + 12'(n)) begin
        mapped  = 1'b1;
        old_val = {31'd0, hpm_en[n]};
      end
    end

    // Bxx are the machine counters, Cxx their read-only user shadows.
    for (int i = 0; i < NCNT; i++) begin
      if ((d_csr_sel_i[11:8] == 4'hB || d_csr_sel_i[11:8] == 4'hC) &&
          d_csr_sel_i[6:0] == {2'b00, cnt_offset(i)}) begin
        mapped  = 1'b1;
        old_val = d_csr_sel_i[7] ? cnt_ext[i][63:32] : cnt_ext[i][31:0];
      end
    end

    case (d_fun_i[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign x_rd_o              = old_val;
  assign x_csr_write_value_o = new_val;
  assign x_illegal_o         = d_is_csr_i &
                               (~mapped | (wr_intent & (d_csr_sel_i[11:10] == 2'b11)));
  assign commit              = d_is_csr_i & wr_intent & ~x_stall_i & ~x_kill_i & ~x_illegal_o;

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    if (i == 0) begin : g_cy
      assign cnt_inc[i] = ~mcountinhibit[INH_CY];
    end else if (i == 1) begin : g_ir
      assign cnt_inc[i] = retire_i & ~mcountinhibit[INH_IR];
    end else begin : g_hpm
      assign cnt_inc[i] = hpm_event_i[i-2] & hpm_en[i-2] & ~mcountinhibit[INH_HPM+i-2];
    end

    assign cnt_wr_lo[i] = commit && (d_csr_sel_i == (CSR_MCYCLE  | 12'(cnt_offset(i))));
    assign cnt_wr_hi[i] = commit && (d_csr_sel_i == (CSR_MCYCLEH | 12'(cnt_offset(i))));
    assign cnt_ext[i]   = 64'(cnt_val[i]);

    kmkz_csr_counter #(.W(CNT_W)) u_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (cnt_inc[i]),
      .wr_lo_i (cnt_wr_lo[i]),
      .wr_hi_i (cnt_wr_hi[i]),
      .wdata_i (new_val),
      .value_o (cnt_val[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcountinhibit <= '0;
      mscratch      <= '0;
      hpm_en        <= '0;
      mtvec         <= {startup_address[31:2], 2'b00};
    end else if (commit) begin
      case (d_csr_sel_i)
        CSR_MCOUNTINHIBIT: mcountinhibit <= new_val & INH_MASK;
        CSR_MSCRATCH:      mscratch      <= new_val;
        CSR_MTVEC: begin
          mtvec[31:2] <= new_val[31:2];
          // Unsupported mode encodings keep the current mode.
          if (new_val[1:0] == 2'b00 || (new_val[1:0] == 2'b01 && MTVEC_VEC_EN))
            mtvec[1:0] <= new_val[1:0];
        end
        default: ;
      endcase
      for (int n = 0; n < NUM_HPM; n++) begin
        if (d_csr_sel_i == CSR_MHPMEVENT3 + 12'(n))
          hpm_en[n] <= new_val[0];
      end
    end
  end

  assign vector_base_o = {mtvec[31:2], 2'b00};
  assign vector_mode_o = mtvec[1:0];

endmodule

// File: tb/tb_kmkz_csr_unit.sv
// Directed bench for kmkz_csr_unit (NUM_HPM = 2, 64-bit counters, vectored mtvec).
module tb_kmkz_csr_unit;
  import kmkz_csr_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_stall_i, x_kill_i, d_is_csr_i, retire_i;
  logic [2:0]  d_fun_i;
  logic [4:0]  d_csr_imm_i;
  logic [11:0] d_csr_sel_i;
  logic [31:0] d_rs1_i;
  logic [1:0]  hpm_event_i;
  logic [31:0] csr_mstatus_i, csr_mip_i, csr_mie_i, csr_mepc_i, csr_mcause_i;
  logic [31:0] startup_address;
  logic [31:0] x_rd_o, x_csr_write_value_o, vector_base_o;
  logic        x_illegal_o;
  logic [1:0]  vector_mode_o;

  int n_tests = 0;
  int n_fail  = 0;

  kmkz_csr_unit #(.NUM_HPM(2), .CNT_W(64), .MTVEC_VEC_EN(1'b1)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .x_stall_i           (x_stall_i),
    .x_kill_i            (x_kill_i),
    .d_is_csr_i          (d_is_csr_i),
    .d_fun_i             (d_fun_i),
    .d_csr_imm_i         (d_csr_imm_i),
    .d_csr_sel_i         (d_csr_sel_i),
    .d_rs1_i             (d_rs1_i),
    .retire_i            (retire_i),
    .hpm_event_i         (hpm_event_i),
    .csr_mstatus_i       (csr_mstatus_i),
    .csr_mip_i           (csr_mip_i),
    .csr_mie_i           (csr_mie_i),
    .csr_mepc_i          (csr_mepc_i),
    .csr_mcause_i        (csr_mcause_i),
    .startup_address     (startup_address),
    .x_rd_o              (x_rd_o),
    .x_csr_write_value_o (x_csr_write_value_o),
    .x_illegal_o         (x_illegal_o),
    .vector_base_o       (vector_base_o),
    .vector_mode_o       (vector_mode_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    d_is_csr_i  = 1'b0;
    d_fun_i     = 3'b000;
    d_csr_imm_i = 5'd0;
    d_csr_sel_i = 12'h000;
    d_rs1_i     = 32'h0;
    x_kill_i    = 1'b0;
    x_stall_i   = 1'b0;
  endtask

  task automatic issue(input logic [2:0] fun, input logic [11:0] sel,
                       input logic [31:0] rs1, input logic [4:0] imm);
    d_is_csr_i  = 1'b1;
    d_fun_i     = fun;
    d_csr_sel_i = sel;
    d_rs1_i     = rs1;
    d_csr_imm_i = imm;
    #1;
  endtask

  task automatic rd_csr(input logic [11:0] sel, output logic [31:0] v);
    issue(CSR_OP_RSI, sel, 32'h0, 5'd0);
    v = x_rd_o;
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_i = 1'b0;
    startup_address = 32'h0000_0103;
    retire_i = 1'b0;
    hpm_event_i = 2'b00;
    csr_mstatus_i = 32'h0000_1888;
    csr_mie_i     = 32'h0000_0888;
    csr_mepc_i    = 32'h8000_0040;
    csr_mcause_i  = 32'h8000_000B;
    csr_mip_i     = 32'h0000_0080;
    idle();
    #12;
    n_tests++; if (vector_base_o !== 32'h0000_0100) begin n_fail++; $display("FAIL reset_base: got %h expected %h", vector_base_o, 32'h100); end
    n_tests++; if (vector_mode_o !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %h expected %h", vector_mode_o, 2'b00); end
    @(negedge clk_i);
    rst_i = 1'b1;
    rd_csr(CSR_MCYCLE, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mcycle: got %h expected %h", v, 32'h0); end
    repeat (5) @(negedge clk_i);
    rd_csr(CSR_MCYCLE, v);
    n_tests++; if (v !== 32'h5) begin n_fail++; $display("FAIL mcycle_5clk: got %h expected %h", v, 32'h5); end
  endtask

  task automatic test_mcycle_write();
    logic [31:0] v;
    @(negedge clk_i);
    issue(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 5'd0);
    n_tests++; if (x_csr_write_value_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_wval: got %h expected %h", x_csr_write_value_o, 32'hFFFF_FFFF); end
    n_tests++; if (x_illegal_o !== 1'b0) begin n_fail++; $display("FAIL mcycle_illegal: got %b expected 0", x_illegal_o); end
    @(negedge clk_i);
    idle();
    repeat (2) @(negedge clk_i);
    rd_csr(CSR_MCYCLE, v);
    n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL mcycle_wrap_lo: got %h expected %h", v, 32'h1); end
    rd_csr(CSR_MCYCLEH, v);
    n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL mcycle_carry_hi: got %h expected %h", v, 32'h1); end
    rd_csr(CSR_CYCLEH, v);
    n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL cycleh_shadow: got %h expected %h", v, 32'h1); end
    // Write lands on an incrementing cycle: loaded value, no +1, high half kept.
    @(negedge clk_i);
    issue(CSR_OP_RW, CSR_MCYCLE, 32'h0000_0100, 5'd0);
    @(negedge clk_i);
    idle();
    rd_csr(CSR_MCYCLE, v);
    n_tests++; if (v !== 32'h100) begin n_fail++; $display("FAIL mcycle_wr_vs_inc: got %h expected %h", v, 32'h100); end
    rd_csr(CSR_MCYCLEH, v);
    n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL mcycle_hi_hold: got %h expected %h", v, 32'h1); end
  endtask

  task automatic test_minstret();
    logic [31:0] v;
    @(negedge clk_i);
    issue(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF, 5'd0);
    @(negedge clk_i);
    idle();
    rd_csr(CSR_MCOUNTINHIBIT, v);
    n_tests++; if (v !== 32'h0000_001D) begin n_fail++; $display("FAIL inhibit_mask: got %h expected %h", v, 32'h1D); end
    issue(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'h4, 5'd0);
    @(negedge clk_i);
    idle();
    retire_i = 1'b1;
    repeat (3) @(negedge clk_i);
    retire_i = 1'b0;
    rd_csr(CSR_MINSTRET, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL minstret_inhibited: got %h expected %h", v, 32'h0); end
    issue(CSR_OP_RCI, CSR_MCOUNTINHIBIT, 32'h0, 5'd4);
    @(negedge clk_i);
    idle();
    rd_csr(CSR_MCOUNTINHIBIT, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL inhibit_clear: got %h expected %h", v, 32'h0); end
    retire_i = 1'b1;
    repeat (3) @(negedge clk_i);
    retire_i = 1'b0;
    rd_csr(CSR_MINSTRET, v);
    n_tests++; if (v !== 32'h3) begin n_fail++; $display("FAIL minstret_count: got %h expected %h", v, 32'h3); end
  endtask

  task automatic test_mtvec_illegal();
    logic [31:0] v;
    @(negedge clk_i);
    issue(CSR_OP_RS, CSR_MTVEC, 32'h0000_F000, 5'd0);
    n_tests++; if (x_illegal_o !== 1'b0) begin n_fail++; $display("FAIL rs_x0_illegal: got %b expected 0", x_illegal_o); end
    n_tests++; if (x_rd_o !== 32'h100) begin n_fail++; $display("FAIL mtvec_read: got %h expected %h", x_rd_o, 32'h100); end
    @(negedge clk_i);
    idle();
    n_tests++; if (vector_base_o !== 32'h100) begin n_fail++; $display("FAIL rs_x0_nowrite: got %h expected %h", vector_base_o, 32'h100); end
    issue(CSR_OP_RW, CSR_CYCLE, 32'h0000_1234, 5'd5);
    n_tests++; if (x_illegal_o !== 1'b1) begin n_fail++; $display("FAIL ro_write_illegal: got %b expected 1", x_illegal_o); end
    issue(CSR_OP_RSI, CSR_CYCLE, 32'h0, 5'd0);
    n_tests++; if (x_illegal_o !== 1'b0) begin n_fail++; $display("FAIL ro_read_legal: got %b expected 0", x_illegal_o); end
    issue(CSR_OP_RSI, 12'h7C0, 32'h0, 5'd0);
    n_tests++; if (x_illegal_o !== 1'b1) begin n_fail++; $display("FAIL unmapped_illegal: got %b expected 1", x_illegal_o); end
    issue(CSR_OP_RW, 12'hC02, 32'h0000_0077, 5'd0);
    @(negedge clk_i);
    idle();
    rd_csr(CSR_MINSTRET, v);
    n_tests++; if (v !== 32'h3) begin n_fail++; $display("FAIL illegal_nowrite: got %h expected %h", v, 32'h3); end
    issue(CSR_OP_RW, CSR_MTVEC, 32'h0000_2003, 5'd0);
    n_tests++; if (x_csr_write_value_o !== 32'h2003) begin n_fail++; $display("FAIL mtvec_wval: got %h expected %h", x_csr_write_value_o, 32'h2003); end
    @(negedge clk_i);
    idle();
    n_tests++; if (vector_base_o !== 32'h2000) begin n_fail++; $display("FAIL mtvec_base: got %h expected %h", vector_base_o, 32'h2000); end
    n_tests++; if (vector_mode_o !== 2'b00) begin n_fail++; $display("FAIL mtvec_mode3_kept: got %h expected %h", vector_mode_o, 2'b00); end
    issue(CSR_OP_RW, CSR_MTVEC, 32'h0000_2001, 5'd0);
    @(negedge clk_i);
    idle();
    n_tests++; if (vector_mode_o !== 2'b01) begin n_fail++; $display("FAIL mtvec_vectored: got %h expected %h", vector_mode_o, 2'b01); end
  endtask

  task automatic test_hpm();
    logic [31:0] v;
    @(negedge clk_i);
    issue(CSR_OP_RWI, CSR_MHPMEVENT3, 32'h0, 5'd1);
    @(negedge clk_i);
    idle();
    rd_csr(CSR_MHPMEVENT3, v);
    n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL hpmevent_en: got %h expected %h", v, 32'h1); end
    hpm_event_i = 2'b11;
    repeat (4) @(negedge clk_i);
    hpm_event_i = 2'b00;
    rd_csr(CSR_MHPMCOUNTER3, v);
    n_tests++; if (v !== 32'h4) begin n_fail++; $display("FAIL hpm3_count: got %h expected %h", v, 32'h4); end
    rd_csr(12'hB04, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL hpm4_disabled: got %h expected %h", v, 32'h0); end
    hpm_event_i = 2'b01;
    issue(CSR_OP_RW, CSR_MHPMCOUNTER3, 32'h10, 5'd0);
    @(negedge clk_i);
    hpm_event_i = 2'b00;
    idle();
    rd_csr(CSR_MHPMCOUNTER3, v);
    n_tests++; if (v !== 32'h10) begin n_fail++; $display("FAIL hpm3_wr_vs_inc: got %h expected %h", v, 32'h10); end
    hpm_event_i = 2'b01;
    @(negedge clk_i);
    hpm_event_i = 2'b00;
    rd_csr(CSR_MHPMCOUNTER3, v);
    n_tests++; if (v !== 32'h11) begin n_fail++; $display("FAIL hpm3_after_wr: got %h expected %h", v, 32'h11); end
    issue(CSR_OP_RW, CSR_MCOUNTINHIBIT, 32'h8, 5'd0);
    @(negedge clk_i);
    idle();
    hpm_event_i = 2'b01;
    @(negedge clk_i);
    hpm_event_i = 2'b00;
    rd_csr(CSR_MHPMCOUNTER3, v);
    n_tests++; if (v !== 32'h11) begin n_fail++; $display("FAIL hpm3_inhibited: got %h expected %h", v, 32'h11); end
  endtask

  task automatic test_mscratch_kill();
    logic [31:0] v;
    @(negedge clk_i);
    issue(CSR_OP_RW, CSR_MSCRATCH, 32'hFF, 5'd0);
    @(negedge clk_i);
    idle();
    x_kill_i = 1'b1;
    issue(CSR_OP_RCI, CSR_MSCRATCH, 32'h0, 5'h0F);
    n_tests++; if (x_rd_o !== 32'hFF) begin n_fail++; $display("FAIL mscratch_old: got %h expected %h", x_rd_o, 32'hFF); end
    n_tests++; if (x_csr_write_value_o !== 32'hF0) begin n_fail++; $display("FAIL rci_wval: got %h expected %h", x_csr_write_value_o, 32'hF0); end
    @(negedge clk_i);
    idle();
    rd_csr(CSR_MSCRATCH, v);
    n_tests++; if (v !== 32'hFF) begin n_fail++; $display("FAIL kill_suppress: got %h expected %h", v, 32'hFF); end
    x_stall_i = 1'b1;
    issue(CSR_OP_RCI, CSR_MSCRATCH, 32'h0, 5'h0F);
    @(negedge clk_i);
    idle();
    rd_csr(CSR_MSCRATCH, v);
    n_tests++; if (v !== 32'hFF) begin n_fail++; $display("FAIL stall_suppress: got %h expected %h", v, 32'hFF); end
    issue(CSR_OP_RCI, CSR_MSCRATCH, 32'h0, 5'h0F);
    @(negedge clk_i);
    idle();
    rd_csr(CSR_MSCRATCH, v);
    n_tests++; if (v !== 32'hF0) begin n_fail++; $display("FAIL rci_commit: got %h expected %h", v, 32'hF0); end
  endtask

  task automatic test_ro_views();
    logic [31:0] v;
    @(negedge clk_i);
    issue(CSR_OP_RW, CSR_MSTATUS, 32'hFFFF_FFFF, 5'd0);
    n_tests++; if (x_illegal_o !== 1'b0) begin n_fail++; $display("FAIL mstatus_wr_legal: got %b expected 0", x_illegal_o); end
    n_tests++; if (x_rd_o !== 32'h1888) begin n_fail++; $display("FAIL mstatus_view: got %h expected %h", x_rd_o, 32'h1888); end
    @(negedge clk_i);
    idle();
    rd_csr(CSR_MISA, v);
    n_tests++; if (v !== 32'h4000_1104) begin n_fail++; $display("FAIL misa: got %h expected %h", v, 32'h40001104); end
    rd_csr(CSR_MEPC, v);
    n_tests++; if (v !== 32'h8000_0040) begin n_fail++; $display("FAIL mepc_view: got %h expected %h", v, 32'h80000040); end
    rd_csr(CSR_MIP, v);
    n_tests++; if (v !== 32'h80) begin n_fail++; $display("FAIL mip_view: got %h expected %h", v, 32'h80); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    @(negedge clk_i);
    issue(CSR_OP_RW, CSR_MSCRATCH, 32'h55, 5'd0);
    @(negedge clk_i);
    idle();
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    n_tests++; if (vector_base_o !== 32'h100) begin n_fail++; $display("FAIL async_base: got %h expected %h", vector_base_o, 32'h100); end
    n_tests++; if (vector_mode_o !== 2'b00) begin n_fail++; $display("FAIL async_mode: got %h expected %h", vector_mode_o, 2'b00); end
    rd_csr(CSR_MSCRATCH, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL async_mscratch: got %h expected %h", v, 32'h0); end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mcycle_write();
    test_minstret();
    test_mtvec_illegal();
    test_hpm();
    test_mscratch_kill();
    test_ro_views();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
